// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and sends them as asynchronous serial
// frames (start bit, WIDTH data bits LSB first, optional parity, stop bit).
// Optional feature macro: PARITY_EN adds an even-parity bit before STOP.
module fifo_uart_tx #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             tx_en,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             shift_out,
  output logic             tx,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, STOP
  } state_t;
`endif

  state_t state, next_state;

  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic [IDX_W-1:0] bit_idx, idx_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             baud_done;
  logic             tx_nxt, busy_nxt, shift_out_nxt;

`ifdef PARITY_EN
  logic par, par_nxt;
`endif

  assign baud_done = (baud_cnt == LAST_CNT);

  // Next-state, counter and shift-register update logic.
  always_comb begin
    next_state = state;
    baud_nxt   = '0;
    idx_nxt    = '0;
    shreg_nxt  = shreg;
`ifdef PARITY_EN
    par_nxt    = par;
`endif
    case (state)
      IDLE: begin
        if (tx_en && !empty) next_state = POP;
      end
      POP: begin
        next_state = LOAD;
      end
      LOAD: begin
        shreg_nxt  = rdata;
`ifdef PARITY_EN
        par_nxt    = ^rdata;
`endif
        next_state = START;
      end
      START: begin
        if (baud_done) next_state = DATA;
        else           baud_nxt   = baud_cnt + CNT_W'(1);
      end
      DATA: begin
        idx_nxt = bit_idx;
        if (baud_done) begin
          shreg_nxt = shreg >> 1;
          if (bit_idx == LAST_IDX) begin
            idx_nxt = '0;
`ifdef PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (baud_done) next_state = STOP;
        else           baud_nxt   = baud_cnt + CNT_W'(1);
      end
`endif
      STOP: begin
        if (baud_done) next_state = IDLE;
        else           baud_nxt   = baud_cnt + CNT_W'(1);
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe instead of lagging it by a cycle.
  always_comb begin
    tx_nxt        = 1'b1;
    busy_nxt      = (next_state != IDLE);
    shift_out_nxt = (next_state == POP);
    case (next_state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
`ifdef PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shift_out <= 1'b0;
    end else begin
      state     <= next_state;
      baud_cnt  <= baud_nxt;
      bit_idx   <= idx_nxt;
      shreg     <= shreg_nxt;
      tx        <= tx_nxt;
      busy      <= busy_nxt;
      shift_out <= shift_out_nxt;
    end
  end

`ifdef PARITY_EN
  // Parity of the word captured in LOAD.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) par <= 1'b0;
    else        par <= par_nxt;
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized self-checking bench for fifo_uart_tx
// (WIDTH=8, CLK_DIV=4) against a frame-level reference model.
module tb_fifo_uart_tx;

  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 4;
`ifdef PARITY_EN
  localparam int FRAME_BITS = WIDTH + 3;
`else
  localparam int FRAME_BITS = WIDTH + 2;
`endif
  // POP + LOAD + serial bits + one IDLE cycle
  localparam int FRAME_CYC = 2 + FRAME_BITS * CLK_DIV + 1;

  logic             clk;
  logic             res_n;
  logic             tx_en;
  logic             empty;
  logic [WIDTH-1:0] rdata;
  logic             shift_out;
  logic             tx;
  logic             busy;

  int checks = 0;
  int passed = 0;

  logic [WIDTH-1:0] fq[$];
  logic             hold;
  logic             tr_tx[$], tr_so[$], tr_busy[$];
  logic [WIDTH-1:0] mw[$];
  logic             exp_tx[$], exp_so[$], exp_busy[$];

  fifo_uart_tx #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .tx_en     (tx_en),
    .empty     (empty),
    .rdata     (rdata),
    .shift_out (shift_out),
    .tx        (tx),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output trace, one sample per cycle shortly after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tr_tx.push_back(tx);
      tr_so.push_back(shift_out);
      tr_busy.push_back(busy);
    end
  end

  // FIFO model: pops on shift_out, presents the word for the following cycle,
  // and drives random garbage on rdata at all other times.
  initial begin
    empty = 1'b1;
    rdata = '0;
    hold  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (shift_out) begin
        if (fq.size() > 0) rdata = fq.pop_front();
        hold = 1'b1;
      end else if (hold) begin
        hold = 1'b0;
      end else begin
        rdata = WIDTH'($urandom);
      end
      empty = (fq.size() == 0);
    end
  end

  // Serial bit b of a frame carrying word w.
  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= WIDTH) return w[b-1];
`ifdef PARITY_EN
    if (b == WIDTH + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Expected per-cycle trace for the words in mw sent back to back, starting
  // with the POP cycle, padded with idle cycles to n entries.
  function automatic void build_expected(input int n);
    exp_tx.delete();
    exp_so.delete();
    exp_busy.delete();
    foreach (mw[k]) begin
      exp_so.push_back(1'b1); exp_busy.push_back(1'b1); exp_tx.push_back(1'b1);
      exp_so.push_back(1'b0); exp_busy.push_back(1'b1); exp_tx.push_back(1'b1);
      for (int b = 0; b < FRAME_BITS; b++)
        for (int c = 0; c < CLK_DIV; c++) begin
          exp_so.push_back(1'b0); exp_busy.push_back(1'b1);
          exp_tx.push_back(frame_bit(mw[k], b));
        end
      exp_so.push_back(1'b0); exp_busy.push_back(1'b0); exp_tx.push_back(1'b1);
    end
    while (exp_tx.size() < n) begin
      exp_so.push_back(1'b0); exp_busy.push_back(1'b0); exp_tx.push_back(1'b1);
    end
  endfunction

  task automatic test_reset();
    int s;
    res_n = 1'b0;
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({shift_out, busy, tx} !== 3'b001)
      $display("FAIL reset_state: so,busy,tx=%b%b%b expected 001", shift_out, busy, tx);
    else passed++;
    res_n = 1'b1;
    s = tr_tx.size();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({tr_so[s+i], tr_busy[s+i], tr_tx[s+i]} !== 3'b001)
        $display("FAIL reset_idle cycle %0d: so,busy,tx=%b%b%b expected 001",
                 i, tr_so[s+i], tr_busy[s+i], tr_tx[s+i]);
      else passed++;
    end
  endtask

  task automatic test_single(input logic [WIDTH-1:0] w);
    int s, n, nb, ns;
    n = FRAME_CYC + 3;
    tx_en = 1'b1;
    fq.push_back(w);
    s = tr_tx.size();
    repeat (n) @(negedge clk);
    mw.delete();
    mw.push_back(w);
    build_expected(n);
    nb = 0;
    ns = 0;
    for (int i = 0; i < n; i++) begin
      nb += int'(tr_busy[s+i]);
      ns += int'(tr_so[s+i]);
      checks++;
      if ({tr_so[s+i], tr_busy[s+i], tr_tx[s+i]} !== {exp_so[i], exp_busy[i], exp_tx[i]})
        $display("FAIL single_%h cycle %0d: so,busy,tx=%b%b%b expected %b%b%b", w, i,
                 tr_so[s+i], tr_busy[s+i], tr_tx[s+i], exp_so[i], exp_busy[i], exp_tx[i]);
      else passed++;
    end
    checks++;
    if (nb !== 2 + FRAME_BITS * CLK_DIV)
      $display("FAIL single_%h busy_cycles: got %0d expected %0d", w, nb, 2 + FRAME_BITS * CLK_DIV);
    else passed++;
    checks++;
    if (ns !== 1)
      $display("FAIL single_%h pop_count: got %0d expected 1", w, ns);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int s, n, ns;
    n = 3 * FRAME_CYC + 4;
    tx_en = 1'b1;
    mw.delete();
    mw.push_back(8'h01); mw.push_back(8'h80); mw.push_back(8'hFF);
    foreach (mw[k]) fq.push_back(mw[k]);
    s = tr_tx.size();
    repeat (n) @(negedge clk);
    build_expected(n);
    ns = 0;
    for (int i = 0; i < n; i++) begin
      ns += int'(tr_so[s+i]);
      checks++;
      if ({tr_so[s+i], tr_busy[s+i], tr_tx[s+i]} !== {exp_so[i], exp_busy[i], exp_tx[i]})
        $display("FAIL back_to_back cycle %0d: so,busy,tx=%b%b%b expected %b%b%b", i,
                 tr_so[s+i], tr_busy[s+i], tr_tx[s+i], exp_so[i], exp_busy[i], exp_tx[i]);
      else passed++;
    end
    checks++;
    if (ns !== 3)
      $display("FAIL back_to_back pop_count: got %0d expected 3", ns);
    else passed++;
  endtask

  task automatic test_tx_en_drop();
    int s, s2, n1, n2;
    logic [WIDTH-1:0] w0, w1;
    w0 = 8'h96;
    w1 = 8'h3C;
    n1 = 60;
    n2 = FRAME_CYC + 3;
    tx_en = 1'b1;
    fq.push_back(w0);
    fq.push_back(w1);
    s = tr_tx.size();
    repeat (2 + 4 * CLK_DIV) @(negedge clk);
    tx_en = 1'b0;
    repeat (n1 - 2 - 4 * CLK_DIV) @(negedge clk);
    checks++;
    if (fq.size() !== 1)
      $display("FAIL tx_en_drop fifo_left: got %0d expected 1", fq.size());
    else passed++;
    tx_en = 1'b1;
    s2 = tr_tx.size();
    repeat (n2) @(negedge clk);
    mw.delete();
    mw.push_back(w0);
    build_expected(n1);
    for (int i = 0; i < n1; i++) begin
      checks++;
      if ({tr_so[s+i], tr_busy[s+i], tr_tx[s+i]} !== {exp_so[i], exp_busy[i], exp_tx[i]})
        $display("FAIL tx_en_drop_first cycle %0d: so,busy,tx=%b%b%b expected %b%b%b", i,
                 tr_so[s+i], tr_busy[s+i], tr_tx[s+i], exp_so[i], exp_busy[i], exp_tx[i]);
      else passed++;
    end
    mw.delete();
    mw.push_back(w1);
    build_expected(n2);
    for (int i = 0; i < n2; i++) begin
      checks++;
      if ({tr_so[s2+i], tr_busy[s2+i], tr_tx[s2+i]} !== {exp_so[i], exp_busy[i], exp_tx[i]})
        $display("FAIL tx_en_drop_second cycle %0d: so,busy,tx=%b%b%b expected %b%b%b", i,
                 tr_so[s2+i], tr_busy[s2+i], tr_tx[s2+i], exp_so[i], exp_busy[i], exp_tx[i]);
      else passed++;
    end
  endtask

  task automatic test_empty();
    int s;
    tx_en = 1'b1;
    s = tr_tx.size();
    repeat (100) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      checks++;
      if ({tr_so[s+i], tr_busy[s+i], tr_tx[s+i]} !== 3'b001)
        $display("FAIL empty_fifo cycle %0d: so,busy,tx=%b%b%b expected 001",
                 i, tr_so[s+i], tr_busy[s+i], tr_tx[s+i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int s, n;
    n = 4 * FRAME_CYC + 4;
    tx_en = 1'b1;
    mw.delete();
    for (int k = 0; k < 4; k++) mw.push_back(WIDTH'($urandom));
    foreach (mw[k]) fq.push_back(mw[k]);
    s = tr_tx.size();
    repeat (n) @(negedge clk);
    build_expected(n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({tr_so[s+i], tr_busy[s+i], tr_tx[s+i]} !== {exp_so[i], exp_busy[i], exp_tx[i]})
        $display("FAIL random_words cycle %0d: so,busy,tx=%b%b%b expected %b%b%b", i,
                 tr_so[s+i], tr_busy[s+i], tr_tx[s+i], exp_so[i], exp_busy[i], exp_tx[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    int s2, n;
    logic [WIDTH-1:0] w1;
    w1 = 8'h5A;
    n = FRAME_CYC + 3;
    tx_en = 1'b1;
    fq.push_back(8'h3C);
    fq.push_back(w1);
    repeat (2 + 3 * CLK_DIV + 1) @(negedge clk);
    res_n = 1'b0;
    #1;
    checks++;
    if ({shift_out, busy, tx} !== 3'b001)
      $display("FAIL midframe_reset_immediate: so,busy,tx=%b%b%b expected 001", shift_out, busy, tx);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({shift_out, busy, tx} !== 3'b001)
        $display("FAIL midframe_reset_hold cycle %0d: so,busy,tx=%b%b%b expected 001",
                 i, shift_out, busy, tx);
      else passed++;
    end
    checks++;
    if (fq.size() !== 1)
      $display("FAIL midframe_reset fifo_left: got %0d expected 1", fq.size());
    else passed++;
    res_n = 1'b1;
    s2 = tr_tx.size();
    repeat (n) @(negedge clk);
    mw.delete();
    mw.push_back(w1);
    build_expected(n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({tr_so[s2+i], tr_busy[s2+i], tr_tx[s2+i]} !== {exp_so[i], exp_busy[i], exp_tx[i]})
        $display("FAIL after_reset cycle %0d: so,busy,tx=%b%b%b expected %b%b%b", i,
                 tr_so[s2+i], tr_busy[s2+i], tr_tx[s2+i], exp_so[i], exp_busy[i], exp_tx[i]);
      else passed++;
    end
  endtask

  initial begin
    res_n = 1'b0;
    tx_en = 1'b0;
    test_reset();
    test_single(8'hA5);
    test_single(8'h07);
    test_back_to_back();
    test_tx_en_drop();
    test_empty();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
